// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// classes, ALU/NPC/GPRSel/WDSel codes and opcode/funct constants.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MEM, CLS_BR, CLS_JMP, CLS_ILL
    } iclass_t;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

    localparam logic [1:0] GPRSel_RD = 2'b00;
    localparam logic [1:0] GPRSel_RT = 2'b01;
    localparam logic [1:0] GPRSel_RA = 2'b10;

    localparam logic [1:0] WDSel_ALU = 2'b00;
    localparam logic [1:0] WDSel_MEM = 2'b01;
    localparam logic [1:0] WDSel_PC  = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: Op/Funct to class, ALU controls,
// destination select and a legal flag.
import ctrl_pkg::*;

module instr_dec (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       alu_src,
    output logic [1:0] gpr_sel,
    output logic       legal
);

    always_comb begin
        cls     = CLS_ILL;
        alu_op  = ALU_NOP;
        ext_op  = 1'b0;
        alu_src = 1'b0;
        gpr_sel = GPRSel_RD;
        legal   = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls   = CLS_ALU;
                legal = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SLLV:         alu_op = ALU_SLLV;
                    default: begin
                        cls   = CLS_ILL;
                        legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                cls     = CLS_ALU;
                legal   = 1'b1;
                alu_src = 1'b1;
                gpr_sel = GPRSel_RT;
                // Logical immediates and lui are zero-extended
                ext_op  = (op == OP_ADDI) || (op == OP_SLTI);
                case (op)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_LUI;
                endcase
            end
            OP_LW, OP_SW: begin
                cls   = CLS_MEM;
                legal = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cls   = CLS_BR;
                legal = 1'b1;
            end
            OP_J, OP_JAL: begin
                cls   = CLS_JMP;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake.
// Optional CTRL_TRAP_EN adds a sticky illegal-instruction trap state and port.
import ctrl_pkg::*;

module mc_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       RegWrite,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       EXTOp,
    output logic       ALUSrc,
    output logic [3:0] ALUOp,
    output logic       instr_done
`ifdef CTRL_TRAP_EN
    ,
    output logic       trap
`endif
);

    state_t     state, state_nxt;
    iclass_t    dec_cls;
    logic [3:0] dec_alu_op;
    logic       dec_ext_op, dec_alu_src, dec_legal;
    logic [1:0] dec_gpr_sel;

    instr_dec u_dec (
        .op      (Op),
        .funct   (Funct),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .alu_src (dec_alu_src),
        .gpr_sel (dec_gpr_sel),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        NPCOp      = NPC_PC4;
        RegWrite   = 1'b0;
        GPRSel     = GPRSel_RD;
        WDSel      = WDSel_ALU;
        EXTOp      = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = ALU_NOP;
        instr_done = 1'b0;
`ifdef CTRL_TRAP_EN
        trap       = 1'b0;
`endif
        // Outputs are gated by reset so an abandoned instruction cannot write
        if (rstn) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        NPCOp     = NPC_PC4;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
`ifdef CTRL_TRAP_EN
                        state_nxt  = S_TRAP;
`else
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
`endif
                    end else begin
                        case (dec_cls)
                            CLS_ALU: state_nxt = S_EXEC;
                            CLS_MEM: state_nxt = S_MEMADR;
                            CLS_BR:  state_nxt = S_BRANCH;
                            CLS_JMP: state_nxt = S_JUMP;
                            default: state_nxt = S_FETCH;
                        endcase
                    end
                end
                S_EXEC: begin
                    ALUOp     = dec_alu_op;
                    ALUSrc    = dec_alu_src;
                    EXTOp     = dec_ext_op;
                    state_nxt = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    WDSel      = WDSel_ALU;
                    GPRSel     = dec_gpr_sel;
                    ALUOp      = dec_alu_op;
                    ALUSrc     = dec_alu_src;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEMADR: begin
                    ALUOp     = ALU_ADD;
                    ALUSrc    = 1'b1;
                    EXTOp     = 1'b1;
                    state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) state_nxt = S_MEMWB;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    WDSel      = WDSel_MEM;
                    GPRSel     = GPRSel_RT;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    ALUOp      = ALU_SUB;
                    NPCOp      = NPC_BR;
                    PCWrite    = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JMP;
                    if (Op == OP_JAL) begin
                        RegWrite = 1'b1;
                        GPRSel   = GPRSel_RA;
                        WDSel    = WDSel_PC;
                    end
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_TRAP: begin
`ifdef CTRL_TRAP_EN
                    trap = 1'b1;
`endif
                    state_nxt = S_TRAP;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule
